tl_get_fragment_sequencer: RTL and testbench

- Splits oversized TileLink A-channel Get requests into a sequence of smaller Gets, each of size MAX_FRAG_LG.
- Holds the original request and replays it with an advancing address. It owns the hold/replay ("repeat") control for the A path.
- Sits between a client A-channel and a slave that supports at most 2^MAX_FRAG_LG-byte transfers.
- Emits fragment index/first/last sideband so the D-side can reassemble responses.

---
 rtl/tl_get_fragment_sequencer.sv | 126 ++++++++++++
 tb/tb_tl_get_fragment_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_get_fragment_sequencer.sv
// Splits oversized TileLink A-channel Gets into 2^MAX_FRAG_LG-byte fragments and replays the
// held request with an advancing address; all other requests pass straight through.
module tl_get_fragment_sequencer #(
   parameter int unsigned MAX_FRAG_LG = 3,
   parameter logic [2:0]  FRAG_OPCODE = 3'd4
) (
   input  logic        clock,
   input  logic        reset,
   output logic        in_ready,
   input  logic        in_valid,
   input  logic [2:0]  in_opcode,
   input  logic [2:0]  in_param,
   input  logic [2:0]  in_size,
   input  logic [6:0]  in_source,
   input  logic [11:0] in_address,
   input  logic [7:0]  in_mask,
   input  logic        in_corrupt,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [2:0]  out_opcode,
   output logic [2:0]  out_param,
   output logic [2:0]  out_size,
   output logic [6:0]  out_source,
   output logic [11:0] out_address,
   output logic [7:0]  out_mask,
   output logic        out_corrupt,
   output logic [3:0]  out_frag_idx,
   output logic        out_frag_first,
   output logic        out_frag_last,
   output logic        busy
);

   typedef enum logic {StIdle, StBurst} state_e;

   localparam logic [2:0] FragSize = 3'(MAX_FRAG_LG);

   state_e      r_state;
   logic [3:0]  r_count;
   logic [3:0]  r_total_m1;
   logic [2:0]  r_opcode;
   logic [2:0]  r_param;
   logic [6:0]  r_source;
   logic [11:0] r_address;
   logic [7:0]  r_mask;
   logic        r_corrupt;

   logic        w_split;
   logic [2:0]  w_shift;
   logic [3:0]  w_total_m1;
   logic        w_count_last;

   assign w_split      = (in_opcode == FRAG_OPCODE) && (in_size > FragSize);
   assign w_shift      = in_size - FragSize;
   // total-1 = 2^shift - 1, built as a low-ones mask so 16 fragments still fit in 4 bits
   assign w_total_m1   = ~(4'hF << w_shift);
   assign w_count_last = (r_count == r_total_m1);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= StIdle;
         r_count <= 4'd0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (in_valid && out_ready && w_split) begin
                  r_state    <= StBurst;
                  r_count    <= 4'd1;
                  r_total_m1 <= w_total_m1;
                  r_opcode   <= in_opcode;
                  r_param    <= in_param;
                  r_source   <= in_source;
                  r_address  <= in_address;
                  r_mask     <= in_mask;
                  r_corrupt  <= in_corrupt;
               end
            end
            StBurst: begin
               if (out_ready) begin
                  if (w_count_last) begin
                     r_state <= StIdle;
                     r_count <= 4'd0;
                  end else begin
                     r_count <= r_count + 4'd1;
                  end
               end
            end
            default: begin
               r_state <= StIdle;
               r_count <= 4'd0;
            end
         endcase
      end
   end

   always_comb begin
      in_ready       = out_ready;
      out_valid      = in_valid;
      out_opcode     = in_opcode;
      out_param      = in_param;
      out_size       = w_split ? FragSize : in_size;
      out_source     = in_source;
      out_address    = in_address;
      out_mask       = in_mask;
      out_corrupt    = in_corrupt;
      out_frag_idx   = 4'd0;
      out_frag_first = 1'b1;
      out_frag_last  = !w_split;
      if (r_state == StBurst) begin
         in_ready       = 1'b0;
         out_valid      = 1'b1;
         out_opcode     = r_opcode;
         out_param      = r_param;
         out_size       = FragSize;
         out_source     = r_source;
         out_address    = r_address + (12'(r_count) << MAX_FRAG_LG);
         out_mask       = r_mask;
         out_corrupt    = r_corrupt;
         out_frag_idx   = r_count;
         out_frag_first = 1'b0;
         out_frag_last  = w_count_last;
      end
   end

   assign busy = (r_state == StBurst);

endmodule

// File: tb/tb_tl_get_fragment_sequencer.sv
// Directed bench for tl_get_fragment_sequencer (MAX_FRAG_LG=3, FRAG_OPCODE=4).
module tb_tl_get_fragment_sequencer;

   logic        clock;
   logic        reset;
   logic        in_ready;
   logic        in_valid;
   logic [2:0]  in_opcode;
   logic [2:0]  in_param;
   logic [2:0]  in_size;
   logic [6:0]  in_source;
   logic [11:0] in_address;
   logic [7:0]  in_mask;
   logic        in_corrupt;
   logic        out_ready;
   logic        out_valid;
   logic [2:0]  out_opcode;
   logic [2:0]  out_param;
   logic [2:0]  out_size;
   logic [6:0]  out_source;
   logic [11:0] out_address;
   logic [7:0]  out_mask;
   logic        out_corrupt;
   logic [3:0]  out_frag_idx;
   logic        out_frag_first;
   logic        out_frag_last;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;
   int fire_cnt = 0;

   tl_get_fragment_sequencer #(
      .MAX_FRAG_LG (3),
      .FRAG_OPCODE (3'd4)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .in_ready       (in_ready),
      .in_valid       (in_valid),
      .in_opcode      (in_opcode),
      .in_param       (in_param),
      .in_size        (in_size),
      .in_source      (in_source),
      .in_address     (in_address),
      .in_mask        (in_mask),
      .in_corrupt     (in_corrupt),
      .out_ready      (out_ready),
      .out_valid      (out_valid),
      .out_opcode     (out_opcode),
      .out_param      (out_param),
      .out_size       (out_size),
      .out_source     (out_source),
      .out_address    (out_address),
      .out_mask       (out_mask),
      .out_corrupt    (out_corrupt),
      .out_frag_idx   (out_frag_idx),
      .out_frag_first (out_frag_first),
      .out_frag_last  (out_frag_last),
      .busy           (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (!reset && out_valid && out_ready) fire_cnt++;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic mid();
      @(negedge clock);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic req(input logic [2:0] op, input logic [2:0] size, input logic [6:0] src,
                      input logic [11:0] addr, input logic [7:0] mask);
      in_valid   = 1'b1;
      in_opcode  = op;
      in_param   = 3'd0;
      in_size    = size;
      in_source  = src;
      in_address = addr;
      in_mask    = mask;
      in_corrupt = 1'b0;
   endtask

   // Drop the request and scramble the fields so burst beats must come from saved state.
   task automatic drop();
      in_valid   = 1'b0;
      in_opcode  = 3'd1;
      in_size    = 3'd0;
      in_source  = 7'h00;
      in_address = 12'hFFF;
      in_mask    = 8'h00;
   endtask

   task automatic beat(input string tag, input logic [11:0] addr, input logic [3:0] idx,
                       input logic first, input logic last, input logic busy_e,
                       input logic [2:0] size_e);
      check({tag, ".valid"}, out_valid, 1);
      check({tag, ".addr"}, out_address, addr);
      check({tag, ".idx"}, out_frag_idx, idx);
      check({tag, ".first"}, out_frag_first, first);
      check({tag, ".last"}, out_frag_last, last);
      check({tag, ".busy"}, busy, busy_e);
      check({tag, ".size"}, out_size, size_e);
   endtask

   int base;

   initial begin
      reset     = 1'b1;
      out_ready = 1'b1;
      in_param  = 3'd0;
      in_corrupt = 1'b0;
      drop();
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      mid();
      check("rst.busy", busy, 0);
      check("rst.out_valid", out_valid, 0);
      check("rst.in_ready", in_ready, 1);
      tick();

      // Pass-through Put
      req(3'd0, 3'd3, 7'h05, 12'h040, 8'hFF);
      mid();
      beat("pt", 12'h040, 4'd0, 1, 1, 0, 3'd3);
      check("pt.opcode", out_opcode, 0);
      check("pt.mask", out_mask, 8'hFF);
      check("pt.source", out_source, 7'h05);
      check("pt.in_ready", in_ready, 1);
      tick();
      drop();
      mid();
      check("pt.after.busy", busy, 0);
      tick();

      // Basic split: size-5 Get -> 4 fragments
      req(3'd4, 3'd5, 7'h2A, 12'h100, 8'hFF);
      mid();
      beat("sp0", 12'h100, 4'd0, 1, 0, 0, 3'd3);
      check("sp0.in_ready", in_ready, 1);
      tick();
      drop();
      mid();
      beat("sp1", 12'h108, 4'd1, 0, 0, 1, 3'd3);
      check("sp1.in_ready", in_ready, 0);
      check("sp1.source", out_source, 7'h2A);
      check("sp1.opcode", out_opcode, 3'd4);
      check("sp1.mask", out_mask, 8'hFF);
      tick();
      mid();
      beat("sp2", 12'h110, 4'd2, 0, 0, 1, 3'd3);
      check("sp2.in_ready", in_ready, 0);
      tick();
      mid();
      beat("sp3", 12'h118, 4'd3, 0, 1, 1, 3'd3);
      check("sp3.in_ready", in_ready, 0);
      check("sp3.source", out_source, 7'h2A);
      tick();
      mid();
      check("sp.end.busy", busy, 0);
      check("sp.end.in_ready", in_ready, 1);
      check("sp.end.out_valid", out_valid, 0);
      tick();

      // Backpressure at idx 2
      base = fire_cnt;
      req(3'd4, 3'd5, 7'h2A, 12'h100, 8'hFF);
      mid();
      beat("bp0", 12'h100, 4'd0, 1, 0, 0, 3'd3);
      tick();
      drop();
      mid();
      beat("bp1", 12'h108, 4'd1, 0, 0, 1, 3'd3);
      tick();
      out_ready = 1'b0;
      mid();
      beat("bp2.stall0", 12'h110, 4'd2, 0, 0, 1, 3'd3);
      tick();
      mid();
      beat("bp2.stall1", 12'h110, 4'd2, 0, 0, 1, 3'd3);
      tick();
      out_ready = 1'b1;
      mid();
      beat("bp2.go", 12'h110, 4'd2, 0, 0, 1, 3'd3);
      tick();
      mid();
      beat("bp3", 12'h118, 4'd3, 0, 1, 1, 3'd3);
      tick();
      mid();
      check("bp.fires", fire_cnt - base, 4);
      check("bp.end.busy", busy, 0);
      tick();

      // Max size: 16 fragments up to the top of the address space
      req(3'd4, 3'd7, 7'h11, 12'hF80, 8'hFF);
      for (int i = 0; i < 16; i++) begin
         mid();
         check($sformatf("max%0d.addr", i), out_address, 12'hF80 + 12'(i * 8));
         check($sformatf("max%0d.idx", i), out_frag_idx, i);
         check($sformatf("max%0d.last", i), out_frag_last, (i == 15));
         check($sformatf("max%0d.valid", i), out_valid, 1);
         tick();
         drop();
      end
      mid();
      check("max.end.busy", busy, 0);
      check("max.end.in_ready", in_ready, 1);
      tick();

      // Back-to-back: size-4 Get then a size-3 Get with no bubble
      req(3'd4, 3'd4, 7'h03, 12'hA00, 8'hFF);
      mid();
      beat("b2b0", 12'hA00, 4'd0, 1, 0, 0, 3'd3);
      tick();
      req(3'd4, 3'd3, 7'h04, 12'h300, 8'h0F);
      mid();
      beat("b2b1", 12'hA08, 4'd1, 0, 1, 1, 3'd3);
      check("b2b1.in_ready", in_ready, 0);
      check("b2b1.source", out_source, 7'h03);
      tick();
      mid();
      beat("b2b2", 12'h300, 4'd0, 1, 1, 0, 3'd3);
      check("b2b2.in_ready", in_ready, 1);
      check("b2b2.source", out_source, 7'h04);
      check("b2b2.mask", out_mask, 8'h0F);
      tick();
      drop();
      mid();
      check("b2b.end.busy", busy, 0);
      tick();

      // Reset mid-burst of a size-6 Get
      req(3'd4, 3'd6, 7'h22, 12'h200, 8'hFF);
      mid();
      beat("rm0", 12'h200, 4'd0, 1, 0, 0, 3'd3);
      tick();
      drop();
      mid();
      beat("rm1", 12'h208, 4'd1, 0, 0, 1, 3'd3);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      mid();
      check("rm.busy", busy, 0);
      check("rm.in_ready", in_ready, 1);
      check("rm.out_valid", out_valid, 0);
      tick();
      req(3'd4, 3'd3, 7'h09, 12'h208, 8'hFF);
      mid();
      beat("rm.new", 12'h208, 4'd0, 1, 1, 0, 3'd3);
      check("rm.new.source", out_source, 7'h09);
      tick();
      drop();
      mid();
      check("rm.new.after.busy", busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
